// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the IITB CPU: program-counter width and address type.
package cpu_pkg;

  localparam int PC_WIDTH = 6;

  typedef logic [PC_WIDTH-1:0] addr_t;

endpackage

// File: rtl/pc_adder.sv
// Ripple-carry adder computing a + b + cin modulo 2^WIDTH; the final carry out is dropped.
module pc_adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  // carry[i] is the carry into bit i; no carry is generated out of the top bit.
  logic [WIDTH-1:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/program_counter.sv
// Program-counter register: loads A0+1 (c2=1) or A0+A1+1 (c2=0) when c3=1, else holds.
module program_counter
  import cpu_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic             c2,
  input  logic             c3,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic [WIDTH-1:0] b_sel;

  pc_adder #(.WIDTH(WIDTH)) u_seq_adder (
    .a   (A0),
    .b   ('0),
    .cin (1'b1),
    .sum (b0)
  );

  pc_adder #(.WIDTH(WIDTH)) u_branch_adder (
    .a   (A0),
    .b   (A1),
    .cin (1'b1),
    .sum (b1)
  );

  assign b_sel = c2 ? b0 : b1;

  // Y is not fed back here; the caller closes the loop by driving A0 from Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= '0;
    end else if (c3) begin
      Y <= b_sel;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, sequential/branch loads, hold, wrap and async reset.
module tb_program_counter;

  logic       clk;
  logic       rst_n;
  logic [5:0] A0;
  logic [5:0] A1;
  logic       c2;
  logic       c3;
  logic [5:0] Y;

  int n_vec = 0;
  int n_mis = 0;

  program_counter #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A0    (A0),
    .A1    (A1),
    .c2    (c2),
    .c3    (c3),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] exp);
    n_vec++;
    assert (Y === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed Y=%0d expected %0d", tag, Y, exp);
    end
  endtask

  // Drive inputs on the falling edge, clock them in, sample 1 time unit later.
  task automatic step(input logic [5:0] a0, input logic [5:0] a1,
                      input logic sel, input logic we,
                      input string tag, input logic [5:0] exp);
    @(negedge clk);
    A0 = a0;
    A1 = a1;
    c2 = sel;
    c3 = we;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    c3 = 1'b1;
    c2 = 1'b1;
    A0 = 6'd5;
    A1 = 6'd0;
    #1;
    check("reset_initial", 6'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 6'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 6'd6);

    // Sequential loads
    step(6'd0,  6'd0,  1'b1, 1'b1, "seq_0",  6'd1);
    step(6'd5,  6'd10, 1'b1, 1'b1, "seq_5",  6'd6);
    step(6'd15, 6'd0,  1'b1, 1'b1, "seq_15", 6'd16);
    step(6'd30, 6'd0,  1'b1, 1'b1, "seq_30", 6'd31);
    step(6'd50, 6'd0,  1'b1, 1'b1, "seq_50", 6'd51);

    // Bring Y to 0 via wrap, then close the loop A0=Y for 4 cycles
    step(6'd63, 6'd0, 1'b1, 1'b1, "wrap_63", 6'd0);
    for (int i = 0; i < 4; i++) begin
      step(Y, 6'd0, 1'b1, 1'b1, "closed_loop", 6'(i + 1));
    end

    // Branch loads
    step(6'd0,  6'd0,  1'b0, 1'b1, "br_0_0",   6'd1);
    step(6'd5,  6'd10, 1'b0, 1'b1, "br_5_10",  6'd16);
    step(6'd10, 6'd20, 1'b0, 1'b1, "br_10_20", 6'd31);
    step(6'd8,  6'd7,  1'b0, 1'b1, "br_8_7",   6'd16);
    step(6'd15, 6'd5,  1'b0, 1'b1, "br_15_5",  6'd21);
    step(6'd12, 6'd8,  1'b0, 1'b1, "br_12_8",  6'd21);

    // Branch chain from PC=4
    step(6'd3, 6'd0, 1'b1, 1'b1, "pc_to_4", 6'd4);
    step(Y, 6'd10, 1'b0, 1'b1, "br_from_4", 6'd15);
    step(Y, 6'd5,  1'b0, 1'b1, "br_from_15", 6'd21);

    // Hold with c3=0
    step(6'd10, 6'd5,  1'b1, 1'b0, "hold_1", 6'd21);
    step(6'd20, 6'd10, 1'b0, 1'b0, "hold_2", 6'd21);
    step(6'd50, 6'd15, 1'b1, 1'b0, "hold_3", 6'd21);
    step(6'd12, 6'd0,  1'b1, 1'b1, "after_hold", 6'd13);

    // Wrap-around
    step(6'd63, 6'd0, 1'b1, 1'b1, "wrap_seq_63", 6'd0);
    step(6'd62, 6'd0, 1'b1, 1'b1, "seq_62",      6'd63);
    step(6'd60, 6'd3, 1'b0, 1'b1, "wrap_br_60_3", 6'd0);

    // Asynchronous reset between edges; pending load must be lost
    step(6'd15, 6'd5, 1'b0, 1'b1, "pre_reset", 6'd21);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 6'd0);
    @(posedge clk);
    #1;
    check("reset_over_c3", 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Control toggle
    step(6'd20, 6'd5, 1'b1, 1'b1, "ctl_seq",  6'd21);
    step(6'd20, 6'd5, 1'b0, 1'b1, "ctl_br",   6'd26);
    step(6'd20, 6'd5, 1'b0, 1'b0, "ctl_hold", 6'd26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
